sp_ram_ctrl: RTL
================

# sp_ram_ctrl

Request/response front-end for the single-port synchronous RAM (`sp_ram`): accepts valid/ready read and write requests from a pipeline memory stage and drives the RAM's enable/address/data pins. It absorbs the RAM's one-cycle read latency through a 2-entry response buffer, so read responses can be back-pressured. Optionally it performs byte-masked writes as read-modify-write, since the RAM has no byte enables.

## Interface
- DATA_WIDTH, 32, word width; multiple of 8
- ADDR_WIDTH, 10, word address width; RAM depth 2**ADDR_WIDTH
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (localparam)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_be  in  BE_WIDTH  byte enables for writes; bit i covers bits [8i+7:8i]
- rsp_valid  out  1  read data available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data, in request order
- ram_rd_ena  out  1  to RAM rd_ena
- ram_wr_ena  out  1  to RAM wr_ena
- ram_address  out  ADDR_WIDTH  to RAM address
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data (valid the cycle after ram_rd_ena; held otherwise)

## Operation
- FSM states: IDLE, MERGE (MERGE exists only with SP_RAM_CTRL_RMW_EN).
- Credit count = inflight (reads issued last cycle, 0/1) + buffer occupancy (0..2) − pop (rsp_valid & rsp_ready this cycle).
- IDLE: req_ready = 1 for writes; for reads, req_ready = (credit < 2). req_ready is combinational and may depend on rsp_ready.
- Accepted read: ram_rd_ena=1, ram_address=req_addr same cycle. The next cycle, ram_rd_data is pushed into the response buffer.
- Accepted write with req_be all ones: ram_wr_ena=1, address/data from the request the same cycle; stays IDLE.
- Accepted write with req_be all zeros: accepted, no RAM access.
- Accepted partial write (RMW_EN): ram_rd_ena=1 at the request address. Address, wdata and be are latched and the FSM goes to MERGE. The RMW read is never pushed into the response buffer.
- MERGE: req_ready=0. ram_wr_ena=1, ram_address=latched address. ram_wr_data per byte = be ? latched wdata : ram_rd_data. Returns to IDLE.
- Response buffer: 2-entry FIFO, order preserved. Push and pop may occur in the same cycle, and the FIFO never overflows because of the credit rule.
- RAM outputs when idle: enables 0. Address and data are don't-care but driven from the request.

## Timing
- Reset (rst_n low, asynchronous): FSM=IDLE, inflight=0, buffer empty, rsp_valid=0, rsp_rdata=0, req_ready=0, ram_rd_ena=0, ram_wr_ena=0, ram_address=0, ram_wr_data=0.
- First cycle after reset release: req_ready=1.
- Read latency: accepted in cycle T, rsp_valid=1 in cycle T+2. Sustained throughput is 1 read/cycle with rsp_ready held at 1.
- With rsp_ready=0: at most 2 reads are outstanding, then req_ready=0 for reads. Writes still accepted.
- Full-word write: 1 cycle. Partial write: 2 cycles (accept + MERGE).
- Read after write to the same address in consecutive cycles returns the new data.
- Reset asserted during MERGE: the pending merged write is dropped, and the buffer and inflight read are discarded.

## Configuration
- SP_RAM_CTRL_RMW_EN defined: partial-write RMW path and MERGE state compiled in.
- SP_RAM_CTRL_RMW_EN undefined: req_be ignored, every write is a full-word single-cycle write, no MERGE state.

## Test plan
- Reset: hold rst_n=0 with req_valid=1 -> all outputs 0, no RAM enables. Release -> req_ready=1 next cycle.
- Write 0xDEADBEEF @0x05, then read @0x05 next cycle -> rsp_valid two cycles after read accept, rsp_rdata=0xDEADBEEF.
- Back-to-back reads @0..7 with rsp_ready=1 -> 8 in-order responses on consecutive cycles, no req_ready drop.
- Reads with rsp_ready=0 -> exactly 2 accepted, then req_ready=0. Raising rsp_ready -> responses drain in order and reads resume.
- (RMW_EN) @0x10 holds 0x11223344. Write 0xAABBCCDD with be=0b0101 -> req_ready low one cycle. Read back gives 0x11BB33DD. Without the macro the same sequence gives 0xAABBCCDD.
- Assert rst_n during MERGE -> the location keeps its old value, buffer empty, rsp_valid=0.

Source files
------------

// File: rtl/sp_ram_ctrl.sv
// Valid/ready front-end for a single-port synchronous RAM, with a 2-entry read response buffer.
// Define SP_RAM_CTRL_RMW_EN to compile in byte-masked writes done as read-modify-write (MERGE state).
module sp_ram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    ram_rd_ena,
  output logic                    ram_wr_ena,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic [DATA_WIDTH-1:0]   ram_wr_data,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                       active;
  logic                       inflight;
  logic                       rd_issue;
  logic                       push;
  logic                       pop;
  logic [1:0][DATA_WIDTH-1:0] rsp_buf;
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [1:0]                 count;
  logic [2:0]                 credit;

  assign push      = inflight;
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_valid = (count != 2'd0);
  assign rsp_rdata = rsp_buf[rd_ptr];
  // A slot is reserved for every read in the RAM pipeline, so the buffer can never overflow.
  assign credit    = {2'b0, inflight} + {1'b0, count} - {2'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      inflight <= 1'b0;
      rsp_buf  <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      active   <= 1'b1;
      inflight <= rd_issue;
      if (push) begin
        rsp_buf[wr_ptr] <= ram_rd_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef SP_RAM_CTRL_RMW_EN
  typedef enum logic {IDLE, MERGE} state_t;
  state_t                state, state_nxt;
  logic                  rmw_start;
  logic [ADDR_WIDTH-1:0] mrg_addr;
  logic [DATA_WIDTH-1:0] mrg_wdata;
  logic [BE_WIDTH-1:0]   mrg_be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mrg_addr  <= '0;
      mrg_wdata <= '0;
      mrg_be    <= '0;
    end else begin
      state <= state_nxt;
      if (rmw_start) begin
        mrg_addr  <= req_addr;
        mrg_wdata <= req_wdata;
        mrg_be    <= req_be;
      end
    end
  end
`else
  logic unused_be;
  assign unused_be = ^req_be;
`endif

  always_comb begin
    req_ready   = 1'b0;
    ram_rd_ena  = 1'b0;
    ram_wr_ena  = 1'b0;
    ram_address = req_addr;
    ram_wr_data = req_wdata;
    rd_issue    = 1'b0;
`ifdef SP_RAM_CTRL_RMW_EN
    state_nxt   = state;
    rmw_start   = 1'b0;
`endif
    if (!active) begin
      ram_address = '0;
      ram_wr_data = '0;
    end
`ifdef SP_RAM_CTRL_RMW_EN
    else if (state == MERGE) begin
      // ram_rd_data now holds the old word read in the accept cycle
      ram_wr_ena  = 1'b1;
      ram_address = mrg_addr;
      for (int i = 0; i < BE_WIDTH; i++)
        ram_wr_data[8*i +: 8] = mrg_be[i] ? mrg_wdata[8*i +: 8] : ram_rd_data[8*i +: 8];
      state_nxt = IDLE;
    end
`endif
    else begin
      req_ready = req_we | (credit < 3'd2);
      if (req_valid && req_ready) begin
        if (!req_we) begin
          ram_rd_ena = 1'b1;
          rd_issue   = 1'b1;
        end
`ifdef SP_RAM_CTRL_RMW_EN
        else if (&req_be) ram_wr_ena = 1'b1;
        else if (|req_be) begin
          ram_rd_ena = 1'b1;
          rmw_start  = 1'b1;
          state_nxt  = MERGE;
        end
`else
        else ram_wr_ena = 1'b1;
`endif
      end
    end
  end
endmodule
